// File: rtl/pipe_core_fwd_if.sv
// Control, IMEM load and writeback observation signals of pipe_core_fwd.
// The core takes the slave modport; the driving environment takes master.
interface pipe_core_fwd_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREG       = 16,
    parameter int unsigned IMEM_DEPTH = 64
);
    logic                          run;
    logic                          ld_we;
    logic [$clog2(IMEM_DEPTH)-1:0] ld_addr;
    logic [31:0]                   ld_data;
    logic [XLEN-1:0]               NPC;
    logic [XLEN-1:0]               WB_OUT;
    logic                          wb_valid;
    logic [$clog2(NREG)-1:0]       wb_rd;
    logic                          halted;

    modport master (
        output run, ld_we, ld_addr, ld_data,
        input  NPC, WB_OUT, wb_valid, wb_rd, halted
    );

    modport slave (
        input  run, ld_we, ld_addr, ld_data,
        output NPC, WB_OUT, wb_valid, wb_rd, halted
    );
endinterface

// File: rtl/pipe_core_fwd.sv
// Five-stage in-order core (IF, ID, EX, MEM, WB) for the 4-class ISA with optional
// EX/MEM + MEM/WB forwarding, load-use interlock, branch flush and HALT handling.
module pipe_core_fwd #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREG       = 16,
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned DMEM_DEPTH = 64,
    parameter bit          FWD_EN     = 1'b1
) (
    input logic            clk,
    input logic            RN,
    pipe_core_fwd_if.slave bus
);
    localparam int unsigned RAW = $clog2(NREG);
    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);
    localparam int unsigned SHW = $clog2(XLEN);

    typedef enum logic [2:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSlt, AluSll, AluSrl
    } alu_e;

    typedef struct packed {
        logic            valid;
        logic            wr;
        logic            ld;
        logic            st;
        logic            br;
        logic            bne;
        logic            halt;
        logic            use_imm;
        alu_e            alu;
        logic [RAW-1:0]  rd;
        logic [RAW-1:0]  rs1;
        logic [RAW-1:0]  rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } idex_t;

    typedef struct packed {
        logic            valid;
        logic            wr;
        logic            ld;
        logic            st;
        logic            halt;
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] sd;
    } exmem_t;

    typedef struct packed {
        logic            valid;
        logic            wr;
        logic            halt;
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] res;
    } memwb_t;

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];
    logic [XLEN-1:0] rf_q [NREG];

    logic [XLEN-1:0] pc_q, pc_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [31:0]     ifid_ir_q, ifid_ir_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    idex_t           idex_q, idex_d, dec;
    exmem_t          exmem_q, exmem_d;
    memwb_t          memwb_q, memwb_d;
    logic            fetch_stop_q, fetch_stop_d;
    logic            halted_q;
    logic [XLEN-1:0] wb_out_q;
    logic            wb_valid_q;
    logic [RAW-1:0]  wb_rd_q;

    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_s;
    logic            dec_use1, dec_use2, ex_hit, mem_hit, stall, halt_id, taken;
    logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res, target;
    logic            unused_ir;

    assign f3        = ifid_ir_q[14:12];
    assign imm_i     = {{(XLEN-12){ifid_ir_q[31]}}, ifid_ir_q[31:20]};
    assign imm_s     = {{(XLEN-12){ifid_ir_q[31]}}, ifid_ir_q[31:25], ifid_ir_q[11:7]};
    assign unused_ir = ^ifid_ir_q;

    always_comb begin
        dec          = '0;
        dec.valid    = ifid_valid_q;
        dec.pc       = ifid_pc_q;
        dec.rd       = ifid_ir_q[7 +: RAW];
        dec.rs1      = ifid_ir_q[15 +: RAW];
        dec.rs2      = ifid_ir_q[20 +: RAW];
        dec.imm      = imm_i;
        dec.alu      = AluAdd;
        dec_use1     = 1'b0;
        dec_use2     = 1'b0;
        case (ifid_ir_q[6:0])
            7'h00: begin
                dec.alu = alu_e'(f3);
                if (ifid_ir_q[31:25] == 7'd1) begin
                    if (f3 <= 3'd5) begin
                        dec.wr   = 1'b1;
                        dec_use1 = 1'b1;
                        dec_use2 = 1'b1;
                    end
                end else if (f3 <= 3'd4) begin
                    dec.wr      = 1'b1;
                    dec.use_imm = 1'b1;
                    dec_use1    = 1'b1;
                end
            end
            7'h01: begin
                dec.use_imm = 1'b1;
                if (f3 == 3'd0) begin
                    dec.wr   = 1'b1;
                    dec.ld   = 1'b1;
                    dec_use1 = 1'b1;
                end else if (f3 == 3'd1) begin
                    dec.st   = 1'b1;
                    dec.imm  = imm_s;
                    dec_use1 = 1'b1;
                    dec_use2 = 1'b1;
                end
            end
            7'h02: begin
                if (f3[2:1] == 2'b00) begin
                    dec.br   = 1'b1;
                    dec.bne  = f3[0];
                    dec.imm  = imm_s;
                    dec_use1 = 1'b1;
                    dec_use2 = 1'b1;
                end
            end
            7'h03: begin
                if (f3[2:1] == 2'b00) begin
                    dec.wr   = 1'b1;
                    dec.alu  = f3[0] ? AluSrl : AluSll;
                    dec_use1 = 1'b1;
                    dec_use2 = 1'b1;
                end
            end
            7'h7F:   dec.halt = 1'b1;
            default: ;
        endcase
        if (dec.rd == '0) dec.wr = 1'b0;
        // Write-first register file: the value retiring this cycle is bypassed to ID.
        dec.a = (memwb_q.valid && memwb_q.wr && memwb_q.rd == dec.rs1) ? memwb_q.res
                                                                       : rf_q[dec.rs1];
        dec.b = (memwb_q.valid && memwb_q.wr && memwb_q.rd == dec.rs2) ? memwb_q.res
                                                                       : rf_q[dec.rs2];
    end

    assign ex_hit  = idex_q.valid && idex_q.wr &&
                     ((dec_use1 && idex_q.rd == dec.rs1) || (dec_use2 && idex_q.rd == dec.rs2));
    assign mem_hit = exmem_q.valid && exmem_q.wr &&
                     ((dec_use1 && exmem_q.rd == dec.rs1) || (dec_use2 && exmem_q.rd == dec.rs2));
    assign stall   = ifid_valid_q && (FWD_EN ? (ex_hit && idex_q.ld) : (ex_hit || mem_hit));
    assign halt_id = ifid_valid_q && dec.halt;

    always_comb begin
        fwd_a = idex_q.a;
        fwd_b = idex_q.b;
        if (FWD_EN && exmem_q.valid && exmem_q.wr && exmem_q.rd == idex_q.rs1) begin
            fwd_a = exmem_q.res;
        end else if (FWD_EN && memwb_q.valid && memwb_q.wr && memwb_q.rd == idex_q.rs1) begin
            fwd_a = memwb_q.res;
        end
        if (FWD_EN && exmem_q.valid && exmem_q.wr && exmem_q.rd == idex_q.rs2) begin
            fwd_b = exmem_q.res;
        end else if (FWD_EN && memwb_q.valid && memwb_q.wr && memwb_q.rd == idex_q.rs2) begin
            fwd_b = memwb_q.res;
        end
        op_b = idex_q.use_imm ? idex_q.imm : fwd_b;
        case (idex_q.alu)
            AluSub:  alu_res = fwd_a - op_b;
            AluAnd:  alu_res = fwd_a & op_b;
            AluOr:   alu_res = fwd_a | op_b;
            AluXor:  alu_res = fwd_a ^ op_b;
            AluSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
            AluSll:  alu_res = fwd_a << op_b[SHW-1:0];
            AluSrl:  alu_res = fwd_a >> op_b[SHW-1:0];
            default: alu_res = fwd_a + op_b;
        endcase
        taken  = idex_q.valid && idex_q.br && ((fwd_a == fwd_b) != idex_q.bne);
        target = idex_q.pc + XLEN'(1) + idex_q.imm;
    end

    always_comb begin
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_ir_d    = ifid_ir_q;
        ifid_pc_d    = ifid_pc_q;
        idex_d       = dec;
        fetch_stop_d = fetch_stop_q;
        // A taken branch outranks stalls, run hold and a HALT sitting in ID.
        if (taken) begin
            pc_d         = target;
            ifid_valid_d = 1'b0;
            idex_d.valid = 1'b0;
        end else if (!bus.run || stall) begin
            idex_d.valid = 1'b0;
        end else if (halt_id || fetch_stop_q) begin
            ifid_valid_d = 1'b0;
            fetch_stop_d = 1'b1;
        end else begin
            pc_d         = pc_q + XLEN'(1);
            ifid_valid_d = 1'b1;
            ifid_ir_d    = imem[pc_q[IAW-1:0]];
            ifid_pc_d    = pc_q;
        end

        exmem_d = '{valid: idex_q.valid, wr: idex_q.wr, ld: idex_q.ld, st: idex_q.st,
                    halt: idex_q.halt, rd: idex_q.rd, res: alu_res, sd: fwd_b};
        memwb_d = '{valid: exmem_q.valid, wr: exmem_q.wr, halt: exmem_q.halt, rd: exmem_q.rd,
                    res: exmem_q.ld ? dmem[exmem_q.res[DAW-1:0]] : exmem_q.res};
    end

    always_ff @(posedge clk) begin
        if (bus.ld_we) imem[bus.ld_addr] <= bus.ld_data;
        if (exmem_q.valid && exmem_q.st) dmem[exmem_q.res[DAW-1:0]] <= exmem_q.sd;
    end

    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            pc_q         <= '0;
            ifid_valid_q <= 1'b0;
            ifid_ir_q    <= '0;
            ifid_pc_q    <= '0;
            idex_q       <= '0;
            exmem_q      <= '0;
            memwb_q      <= '0;
            fetch_stop_q <= 1'b0;
            halted_q     <= 1'b0;
            wb_out_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= XLEN'(i);
        end else begin
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_ir_q    <= ifid_ir_d;
            ifid_pc_q    <= ifid_pc_d;
            idex_q       <= idex_d;
            exmem_q      <= exmem_d;
            memwb_q      <= memwb_d;
            fetch_stop_q <= fetch_stop_d;
            halted_q     <= halted_q || (memwb_q.valid && memwb_q.halt);
            wb_valid_q   <= memwb_q.valid && memwb_q.wr;
            if (memwb_q.valid && memwb_q.wr) begin
                rf_q[memwb_q.rd] <= memwb_q.res;
                wb_out_q         <= memwb_q.res;
                wb_rd_q          <= memwb_q.rd;
            end
        end
    end

    assign bus.NPC      = pc_q;
    assign bus.WB_OUT   = wb_out_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.halted   = halted_q;
endmodule

// File: tb/tb_pipe_core_fwd.sv
// Directed bench: runs small programs on a forwarding core (d=0) and an
// interlock-only core (d=1) side by side and checks the writeback stream.
module tb_pipe_core_fwd;
    logic clk;
    logic RN;

    pipe_core_fwd_if #(.XLEN(32), .NREG(16), .IMEM_DEPTH(64)) bus ();
    pipe_core_fwd_if #(.XLEN(32), .NREG(16), .IMEM_DEPTH(64)) bus0 ();

    pipe_core_fwd #(.FWD_EN(1'b1)) dut  (.clk(clk), .RN(RN), .bus(bus));
    pipe_core_fwd #(.FWD_EN(1'b0)) dut0 (.clk(clk), .RN(RN), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] Nop  = 32'h0000_0004;
    localparam logic [31:0] Halt = 32'h0000_007F;

    int          n_vec, n_err;
    logic [31:0] prog [64];
    int          log_n   [2];
    int          log_cyc [2][16];
    int          log_rd  [2][16];
    logic [31:0] log_val [2][16];
    logic [31:0] npc_log [64];
    logic        halt_log[64];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [6:0] f7);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    task automatic drive(input logic run, input logic we, input logic [5:0] addr,
                         input logic [31:0] data);
        bus.run  = run;  bus.ld_we  = we;  bus.ld_addr  = addr;  bus.ld_data  = data;
        bus0.run = run;  bus0.ld_we = we;  bus0.ld_addr = addr;  bus0.ld_data = data;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = Nop;
    endtask

    task automatic load_imem();
        RN = 1'b1;
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, 6'(i), prog[i]);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 6'd0, 32'h0);
    endtask

    task automatic run_prog(input int ncyc);
        RN = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 32'h0);
        @(posedge clk);
        #1;
        check_eq("rst NPC", 64'(bus.NPC), 64'h0);
        check_eq("rst WB_OUT", 64'(bus.WB_OUT), 64'h0);
        check_eq("rst wb_valid", 64'(bus.wb_valid), 64'h0);
        check_eq("rst wb_rd", 64'(bus.wb_rd), 64'h0);
        check_eq("rst halted", 64'(bus.halted), 64'h0);
        for (int d = 0; d < 2; d++) begin
            log_n[d] = 0;
            for (int k = 0; k < 16; k++) begin
                log_cyc[d][k] = -1;
                log_rd[d][k]  = -1;
                log_val[d][k] = 32'hDEAD_BEEF;
            end
        end
        RN = 1'b0;
        drive(1'b1, 1'b0, 6'd0, 32'h0);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            npc_log[c]  = bus.NPC;
            halt_log[c] = bus.halted;
            if (bus.wb_valid) begin
                if (log_n[0] < 16) begin
                    log_cyc[0][log_n[0]] = c;
                    log_rd[0][log_n[0]]  = int'(bus.wb_rd);
                    log_val[0][log_n[0]] = bus.WB_OUT;
                end
                log_n[0]++;
            end
            if (bus0.wb_valid) begin
                if (log_n[1] < 16) begin
                    log_cyc[1][log_n[1]] = c;
                    log_rd[1][log_n[1]]  = int'(bus0.wb_rd);
                    log_val[1][log_n[1]] = bus0.WB_OUT;
                end
                log_n[1]++;
            end
        end
    endtask

    task automatic expect_wb(input string t, input int d, input int k, input int cyc,
                             input int rd, input logic [31:0] val);
        check_eq($sformatf("%s d%0d wb%0d cycle", t, d, k), 64'(log_cyc[d][k]), 64'(cyc));
        check_eq($sformatf("%s d%0d wb%0d rd", t, d, k), 64'(log_rd[d][k]), 64'(rd));
        check_eq($sformatf("%s d%0d wb%0d value", t, d, k), 64'(log_val[d][k]), 64'(val));
    endtask

    task automatic expect_n(input string t, input int d, input int n);
        check_eq($sformatf("%s d%0d wb count", t, d), 64'(log_n[d]), 64'(n));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RN    = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 32'h0);

        // Independent ADD / SUB.
        clear_prog();
        prog[0] = 32'h0220_8300;
        prog[1] = 32'h0220_9380;
        load_imem();
        run_prog(10);
        for (int d = 0; d < 2; d++) begin
            expect_n("addsub", d, 2);
            expect_wb("addsub", d, 0, 5, 6, 32'h3);
            expect_wb("addsub", d, 1, 6, 7, 32'hFFFF_FFFF);
        end

        // Adjacent RAW dependency.
        clear_prog();
        prog[0] = enc_r(7'd0, 5'd6, 3'd0, 5'd1, 5'd2, 7'd1);
        prog[1] = enc_r(7'd0, 5'd7, 3'd0, 5'd6, 5'd6, 7'd1);
        load_imem();
        run_prog(12);
        expect_n("raw", 0, 2);
        expect_wb("raw", 0, 0, 5, 6, 32'h3);
        expect_wb("raw", 0, 1, 6, 7, 32'h6);
        expect_n("raw", 1, 2);
        expect_wb("raw", 1, 0, 5, 6, 32'h3);
        expect_wb("raw", 1, 1, 8, 7, 32'h6);

        // SW r3,2(r1); LW r13,2(r1); ADD r14,r13,r13.
        clear_prog();
        prog[0] = enc_s(7'd1, 3'd1, 5'd1, 5'd3, 12'd2);
        prog[1] = enc_i(7'd1, 5'd13, 3'd0, 5'd1, 12'd2);
        prog[2] = enc_r(7'd0, 5'd14, 3'd0, 5'd13, 5'd13, 7'd1);
        load_imem();
        run_prog(14);
        expect_n("ldu", 0, 2);
        expect_wb("ldu", 0, 0, 6, 13, 32'h3);
        expect_wb("ldu", 0, 1, 8, 14, 32'h6);
        expect_n("ldu", 1, 2);
        expect_wb("ldu", 1, 0, 6, 13, 32'h3);
        expect_wb("ldu", 1, 1, 9, 14, 32'h6);

        // Taken BEQ at 9 to 25, then a not-taken BNE at 26.
        clear_prog();
        prog[9]  = enc_s(7'd2, 3'd0, 5'd0, 5'd0, 12'd15);
        prog[10] = enc_i(7'd0, 5'd10, 3'd0, 5'd0, 12'd10);
        prog[11] = enc_i(7'd0, 5'd11, 3'd0, 5'd0, 12'd11);
        prog[25] = enc_i(7'd0, 5'd12, 3'd0, 5'd0, 12'd25);
        prog[26] = enc_s(7'd2, 3'd1, 5'd0, 5'd0, 12'd5);
        prog[27] = enc_i(7'd0, 5'd13, 3'd0, 5'd0, 12'd27);
        load_imem();
        run_prog(24);
        check_eq("br NPC before redirect", 64'(npc_log[11]), 64'd11);
        check_eq("br NPC after redirect", 64'(npc_log[12]), 64'd25);
        for (int d = 0; d < 2; d++) begin
            expect_n("br", d, 2);
            expect_wb("br", d, 0, 17, 12, 32'd25);
            expect_wb("br", d, 1, 19, 13, 32'd27);
        end

        // HALT at address 3 behind three ADDIs.
        clear_prog();
        prog[0] = enc_i(7'd0, 5'd1, 3'd0, 5'd0, 12'd5);
        prog[1] = enc_i(7'd0, 5'd2, 3'd0, 5'd0, 12'd6);
        prog[2] = enc_i(7'd0, 5'd3, 3'd0, 5'd0, 12'd7);
        prog[3] = Halt;
        prog[4] = enc_i(7'd0, 5'd4, 3'd0, 5'd0, 12'd9);
        load_imem();
        run_prog(20);
        expect_n("halt", 0, 3);
        expect_wb("halt", 0, 0, 5, 1, 32'd5);
        expect_wb("halt", 0, 1, 6, 2, 32'd6);
        expect_wb("halt", 0, 2, 7, 3, 32'd7);
        check_eq("halt halted cyc7", 64'(halt_log[7]), 64'd0);
        check_eq("halt halted cyc8", 64'(halt_log[8]), 64'd1);
        check_eq("halt NPC cyc4", 64'(npc_log[4]), 64'd4);
        check_eq("halt NPC cyc20", 64'(npc_log[20]), 64'd4);

        // Reset in the middle of a run, then re-execute from scratch.
        clear_prog();
        prog[0] = enc_r(7'd0, 5'd1, 3'd0, 5'd1, 5'd1, 7'd1);
        prog[1] = enc_r(7'd0, 5'd2, 3'd0, 5'd1, 5'd1, 7'd1);
        prog[2] = Halt;
        load_imem();
        run_prog(5);
        check_eq("mid wb_valid before RN", 64'(bus.wb_valid), 64'd1);
        #2;
        RN = 1'b1;
        #1;
        check_eq("mid NPC", 64'(bus.NPC), 64'd0);
        check_eq("mid WB_OUT", 64'(bus.WB_OUT), 64'd0);
        check_eq("mid wb_valid", 64'(bus.wb_valid), 64'd0);
        check_eq("mid halted", 64'(bus.halted), 64'd0);
        run_prog(8);
        expect_n("rerun", 0, 2);
        expect_wb("rerun", 0, 0, 5, 1, 32'd2);
        expect_wb("rerun", 0, 1, 6, 2, 32'd4);
        check_eq("rerun halted cyc7", 64'(halt_log[7]), 64'd1);
        expect_wb("rerun", 1, 0, 5, 1, 32'd2);
        expect_wb("rerun", 1, 1, 8, 2, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_core_fwd.md
# pipe_core_fwd

Parametrised five-stage in-order pipelined core (IF, ID, EX, MEM, WB) that succeeds the fixed 32-bit core. It executes the team's custom 4-class ISA with register width, register count, IMEM and DMEM depth set by parameters. Over the fixed core it adds full hazard handling (forwarding, load-use interlock, branch flush), a runtime IMEM load port, run/halt control and a writeback-valid strobe. It is the top-level compute block; the test bench drives it directly.

## Interface
- XLEN, 32: data and register width (≥16).
- NREG, 16: architectural registers, power of 2, ≤32; r0 reads zero.
- IMEM_DEPTH, 64: instruction words, power of 2.
- DMEM_DEPTH, 64: data words, power of 2.
- FWD_EN, 1: 1 = EX/MEM and MEM/WB forwarding; 0 = interlock only.
- clk  in  1  single clock, rising edge.
- RN  in  1  asynchronous, active-high reset.
- run  in  1  1 = fetch enabled; 0 = NPC and IF/ID hold, bubbles enter ID/EX, older stages drain.
- ld_we  in  1  IMEM write strobe.
- ld_addr  in  clog2(IMEM_DEPTH)  IMEM write address.
- ld_data  in  32  IMEM write data.
- NPC  out  XLEN  current fetch PC (word index).
- WB_OUT  out  XLEN  last value written back.
- wb_valid  out  1  pulses for one cycle when WB_OUT updates.
- wb_rd  out  clog2(NREG)  destination of last writeback.
- halted  out  1  sticky; HALT has retired.

## Operation
- Encoding: opcode IR[6:0], rd IR[11:7], funct3 IR[14:12], rs1 IR[19:15], rs2 IR[24:20], funct7 IR[31:25]. Register fields use the low clog2(NREG) bits.
- Immediates: I = sext(IR[31:20]); S/B = sext({IR[31:25],IR[11:7]}). Both are sign-extended to XLEN.
- AR (0): if funct7==1, reg-reg ops by funct3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 1/0). Otherwise reg-imm ops by funct3: 0 ADDI, 1 SUBI, 2 ANDI, 3 ORI, 4 XORI, all with I.
- M (1): funct3 0 LW: rd = DM[rs1+I]. funct3 1 SW: DM[rs1+S] = rs2. The DMEM index is the low clog2(DMEM_DEPTH) bits, wrapping.
- BR (2): funct3 0 BEQ, 1 BNE. Compare rs1 with rs2 (forwarded values). Target = PC+1+B, PC is a word index.
- SH (3): funct3 0 SLL, 1 SRL (logical). Shift amount is rs2[clog2(XLEN)-1:0].
- HALT: opcode 7'h7F.
- Any other opcode/funct3 combination is a NOP: no write, no side effect.
- Writes to r0 are discarded. The register file is write-first: a WB write is visible to an ID read in the same cycle.
- Reset: REG[i] = i, so r0 = 0. DMEM and IMEM are not reset; IMEM contents survive RN.
- Fetch index is NPC[clog2(IMEM_DEPTH)-1:0], wrapping. NPC increments as a full XLEN value, modulo 2^XLEN.

## Timing
- Reset values: NPC=0, WB_OUT=0, wb_valid=0, wb_rd=0, halted=0. All pipeline valid bits are 0 (bubbles).
- Latency: an instruction fetched on edge n writes REG, WB_OUT, wb_rd and wb_valid on edge n+4. Throughput is 1/cycle with no hazards.
- Forwarding (FWD_EN=1): EX operands take EX/MEM first, then MEM/WB, then the RF value. A LW in EX with a dependent instruction in ID causes 1 bubble; NPC and IF/ID hold.
- FWD_EN=0: a dependent instruction in ID stalls while its producer is in EX or MEM. Adjacent dependency costs 2 bubbles.
- Branch resolves in EX. If taken, NPC<=target on the next edge and IF/ID and ID/EX are squashed, a 2-cycle penalty. Not-taken has no penalty.
- Stall and taken branch in the same cycle: the branch wins and the stall is dropped.
- HALT in ID: NPC freezes and younger instructions are squashed. halted=1 on the edge HALT leaves WB; it clears only on RN.
- Taken branch in EX with HALT in ID: HALT is squashed.
- ld_we writes on the edge. A same-edge fetch of that address returns the old word.
- RN mid-operation: all outputs and pipeline state return to reset values immediately. In-flight instructions are lost.

## Test plan
- Load 0x02208300 (ADD r6,r1,r2) and 0x02209380 (SUB r7,r1,r2), RN low, run=1 -> wb_valid on cycles 5 and 6 with WB_OUT=3, then 0xFFFFFFFF; wb_rd = 6, 7.
- ADD r6,r1,r2 then ADD r7,r6,r6 -> FWD_EN=1: WB_OUT 3 then 6 on consecutive cycles. FWD_EN=0: 6 appears 2 cycles later.
- SW r3,2(r1); LW r13,2(r1); ADD r14,r13,r13 -> r13=3, r14=6, with exactly 1 bubble before the ADD retires.
- BEQ r0,r0,+15 at address 9, with distinct ADDIs at 10, 11 and 25 -> NPC jumps to 25, addresses 10 and 11 never assert wb_valid, and the instruction at 25 retires. BNE r0,r0 falls through with no bubble.
- HALT at address 3 after three ADDIs -> three writebacks, then halted=1, NPC constant, no further wb_valid.
- Assert RN during a running program -> NPC=0, halted=0, wb_valid=0 immediately. After release, the program re-executes from 0 with REG re-initialised.
